wb_interconnect_2x1: RTL and testbench



---
 rtl/wb_ic_pkg.sv | 11 +
 rtl/wb_if.sv | 21 ++
 rtl/wb_rr_arb2.sv | 53 +++++
 rtl/wb_interconnect_2x1.sv | 83 ++++++++
 tb/tb_wb_interconnect_2x1.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ic_pkg.sv
// Shared types for the Wishbone interconnect family.
package wb_ic_pkg;

  // Arbitration state: nobody owns the slave, or master 0/1 owns it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } wb_arb_state_e;

endpackage

// File: rtl/wb_if.sv
// Wishbone classic bundle. The master modport is the initiator view and
// the slave modport is the target view.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport master (output adr, dat_w, sel, cyc, stb, we,
                  input  dat_r, ack, err);
  modport slave  (input  adr, dat_w, sel, cyc, stb, we,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter with bus-cycle ownership: a grant
// is held for as long as the owner keeps its request (CYC) high.
module wb_rr_arb2
  import wb_ic_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  output wb_arb_state_e state
);

  wb_arb_state_e state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [1:0]    gnt_q, gnt_d;

  // Next-state: keep the owner while it requests, hand over directly to a
  // waiting requester, and break ties toward the master not served last.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (req[0] && req[1]) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (req[0])      state_d = GNT0;
        else if (req[1])      state_d = GNT1;
      end
      GNT0: if (!req[0]) state_d = req[1] ? GNT1 : IDLE;
      GNT1: if (!req[1]) state_d = req[0] ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q && state_d == GNT0) last_gnt_d = 1'b0;
    if (state_d != state_q && state_d == GNT1) last_gnt_d = 1'b1;
    gnt_d = {state_d == GNT1, state_d == GNT0};
  end

  // State, priority flag and one-hot grant registers; reset gives m0 first turn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign state = state_q;

endmodule

// File: rtl/wb_interconnect_2x1.sv
// Two-master, one-slave Wishbone interconnect. The arbiter owns all state;
// this level only steers the forward signals and gates the return strobes.
module wb_interconnect_2x1
  import wb_ic_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
) (
  input logic  clk,
  input logic  rstn,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s0
);

  localparam int WB_SEL_WIDTH = WB_DATA_WIDTH / 8;

  logic [1:0]               req;
  logic [1:0]               gnt;
  wb_arb_state_e            arb_state;
  logic [WB_ADDR_WIDTH-1:0] adr_mux;
  logic [WB_DATA_WIDTH-1:0] dat_w_mux;
  logic [WB_SEL_WIDTH-1:0]  sel_mux;
  logic                     cyc_mux;
  logic                     stb_mux;
  logic                     we_mux;

  assign req = {m1.cyc, m0.cyc};

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .gnt   (gnt),
    .state (arb_state)
  );

  // Forward mux keyed only by registered state, so s0.ACK never loops back
  // into s0.CYC/STB; the idle bus is driven to all zeros.
  always_comb begin
    adr_mux   = '0;
    dat_w_mux = '0;
    sel_mux   = '0;
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    we_mux    = 1'b0;
    case (arb_state)
      GNT0: begin
        adr_mux   = m0.adr;
        dat_w_mux = m0.dat_w;
        sel_mux   = m0.sel;
        cyc_mux   = m0.cyc;
        stb_mux   = m0.stb;
        we_mux    = m0.we;
      end
      GNT1: begin
        adr_mux   = m1.adr;
        dat_w_mux = m1.dat_w;
        sel_mux   = m1.sel;
        cyc_mux   = m1.cyc;
        stb_mux   = m1.stb;
        we_mux    = m1.we;
      end
      default: ;
    endcase
  end

  assign s0.adr   = adr_mux;
  assign s0.dat_w = dat_w_mux;
  assign s0.sel   = sel_mux;
  assign s0.cyc   = cyc_mux;
  assign s0.stb   = stb_mux;
  assign s0.we    = we_mux;

  // Only the owner sees the slave's strobes; read data is shared.
  assign m0.ack   = gnt[0] & s0.ack;
  assign m0.err   = gnt[0] & s0.err;
  assign m1.ack   = gnt[1] & s0.ack;
  assign m1.err   = gnt[1] & s0.err;
  assign m0.dat_r = s0.dat_r;
  assign m1.dat_r = s0.dat_r;

endmodule

// File: tb/tb_wb_interconnect_2x1.sv
// Bench for wb_interconnect_2x1: two task-driven masters, a behavioural
// memory slave, a cycle-level ownership model and a reference memory.
module tb_wb_interconnect_2x1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  wb_if m0_if ();
  wb_if m1_if ();
  wb_if s0_if ();

  wb_interconnect_2x1 dut (
    .clk  (clk),
    .rstn (rstn),
    .m0   (m0_if),
    .m1   (m1_if),
    .s0   (s0_if)
  );

  // Master-side drive and observe arrays, index = master number.
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic [31:0] m_datr [2];

  assign m0_if.cyc = m_cyc[0];  assign m1_if.cyc = m_cyc[1];
  assign m0_if.stb = m_stb[0];  assign m1_if.stb = m_stb[1];
  assign m0_if.we  = m_we[0];   assign m1_if.we  = m_we[1];
  assign m0_if.adr = m_adr[0];  assign m1_if.adr = m_adr[1];
  assign m0_if.dat_w = m_dat[0]; assign m1_if.dat_w = m_dat[1];
  assign m0_if.sel = m_sel[0];  assign m1_if.sel = m_sel[1];
  assign m_ack[0]  = m0_if.ack; assign m_ack[1]  = m1_if.ack;
  assign m_err[0]  = m0_if.err; assign m_err[1]  = m1_if.err;
  assign m_datr[0] = m0_if.dat_r; assign m_datr[1] = m1_if.dat_r;

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural slave: registered ACK one cycle after STB, ERR for adr[12].
  logic [31:0] slave_mem [1024];
  bit          slave_vld [1024];
  logic        s_ack_q  = 1'b0;
  logic        s_err_q  = 1'b0;
  logic [31:0] s_datr_q = '0;

  function automatic logic [31:0] slave_rd(input int idx);
    return slave_vld[idx] ? slave_mem[idx] : 32'h0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ack_q  <= 1'b0;
      s_err_q  <= 1'b0;
      s_datr_q <= '0;
    end else begin
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      if (s0_if.cyc && s0_if.stb && !s_ack_q && !s_err_q) begin
        if (s0_if.adr[12]) s_err_q <= 1'b1;
        else begin
          s_ack_q  <= 1'b1;
          s_datr_q <= slave_rd(int'(s0_if.adr[11:2]));
          if (s0_if.we) begin
            slave_mem[int'(s0_if.adr[11:2])] <=
              merge_word(slave_rd(int'(s0_if.adr[11:2])), s0_if.dat_w, s0_if.sel);
            slave_vld[int'(s0_if.adr[11:2])] <= 1'b1;
          end
        end
      end
    end
  end

  assign s0_if.ack   = s_ack_q;
  assign s0_if.err   = s_err_q;
  assign s0_if.dat_r = s_datr_q;

  // Reference memory, updated when a write is seen to complete.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [31:0] adr);
    int idx = int'(adr[11:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    ref_mem[int'(adr[11:2])] = merge_word(ref_rd(adr), d, sel);
  endtask

  // Ownership model: -1 = nobody, else master index.
  int owner_m = -1;
  int last_m  = 1;
  int ack_cnt [2];

  function automatic int arb_next(input int owner, input int last, input logic c0, input logic c1);
    if (owner == 0 && c0) return 0;
    if (owner == 1 && c1) return 1;
    if (c0 && c1) return (last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_m <= -1;
      last_m  <= 1;
    end else begin
      if (arb_next(owner_m, last_m, m_cyc[0], m_cyc[1]) >= 0 &&
          arb_next(owner_m, last_m, m_cyc[0], m_cyc[1]) != owner_m)
        last_m <= arb_next(owner_m, last_m, m_cyc[0], m_cyc[1]);
      owner_m <= arb_next(owner_m, last_m, m_cyc[0], m_cyc[1]);
    end
  end

  function automatic logic [70:0] fwd_of(input int o);
    if (o < 0) return '0;
    return {m_cyc[o], m_stb[o], m_we[o], m_adr[o], m_dat[o], m_sel[o]};
  endfunction

  // Per-cycle check of the forward mux and the return-path gating.
  always @(negedge clk) begin
    logic [70:0] act_fwd;
    act_fwd = {s0_if.cyc, s0_if.stb, s0_if.we, s0_if.adr, s0_if.dat_w, s0_if.sel};
    vectors++;
    if (act_fwd !== fwd_of(owner_m)) begin
      miscompares++;
      $display("FAIL fwd_mux t=%0t owner=%0d got=%h want=%h", $time, owner_m, act_fwd, fwd_of(owner_m));
    end
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if ({m_ack[m], m_err[m]} !== ((owner_m == m) ? {s_ack_q, s_err_q} : 2'b00)) begin
        miscompares++;
        $display("FAIL ret_gate m%0d t=%0t owner=%0d got ack/err=%b%b want=%b%b", m, $time, owner_m,
                 m_ack[m], m_err[m], (owner_m == m) & s_ack_q, (owner_m == m) & s_err_q);
      end
      vectors++;
      if (m_datr[m] !== s_datr_q) begin
        miscompares++;
        $display("FAIL dat_r_bcast m%0d t=%0t got=%h want=%h", m, $time, m_datr[m], s_datr_q);
      end
      if (m_ack[m] === 1'b1) ack_cnt[m]++;
    end
  end

  int          done_q [$];
  logic [31:0] rd_buf [2][8];

  // One Wishbone cycle of 'beats' beats; status 0 ok, 1 timeout, 2 reset abort.
  task automatic xfer(input int m, input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, input int beats, output bit err, output int status);
    int cnt;
    status = 0;
    err    = 1'b0;
    m_cyc[m] = 1'b1;
    m_we[m]  = we;
    m_sel[m] = sel;
    for (int b = 0; b < beats && status == 0; b++) begin
      m_adr[m] = adr + 32'(4 * b);
      m_dat[m] = wdat + 32'(b);
      m_stb[m] = 1'b1;
      cnt = 0;
      forever begin
        @(posedge clk); #1;
        cnt++;
        if (!rstn) begin status = 2; break; end
        if (m_ack[m] || m_err[m]) break;
        if (cnt >= 300) begin status = 1; break; end
      end
      if (status == 0) begin
        rd_buf[m][b] = m_datr[m];
        if (m_err[m]) err = 1'b1;
      end
      m_stb[m] = 1'b0;
    end
    m_cyc[m] = 1'b0;
    m_we[m]  = 1'b0;
    if (status == 0) done_q.push_back(m);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit e0, e1;
    int st0, st1;
    rstn = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (s0_if.cyc !== 1'b0) begin
      miscompares++; $display("FAIL reset_s0_cyc got=%b want=0", s0_if.cyc);
    end
    vectors++;
    if ({s0_if.stb, s0_if.we} !== 2'b00) begin
      miscompares++; $display("FAIL reset_s0_stb_we got=%b want=00", {s0_if.stb, s0_if.we});
    end
    vectors++;
    if ({m1_if.ack, m0_if.ack, m1_if.err, m0_if.err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ack_err got=%b want=0000", {m1_if.ack, m0_if.ack, m1_if.err, m0_if.err});
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    done_q.delete();
    fork
      xfer(0, 1'b1, 32'h100, 32'hA5A5_0001, 4'hF, 1, e0, st0);
      xfer(1, 1'b1, 32'h104, 32'h5A5A_0002, 4'hF, 1, e1, st1);
    join
    if (st0 == 0) ref_wr(32'h100, 32'hA5A5_0001, 4'hF);
    if (st1 == 0) ref_wr(32'h104, 32'h5A5A_0002, 4'hF);
    vectors++;
    if (st0 != 0 || st1 != 0) begin
      miscompares++; $display("FAIL reset_first_status got=%0d/%0d want=0/0", st0, st1);
    end
    vectors++;
    if (done_q.size() != 2 || done_q[0] != 0) begin
      miscompares++; $display("FAIL reset_first_grant got_first=%0d want=0", (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  task automatic test_contention();
    bit e0, e1;
    int st0, st1, exp_first;
    exp_first = (last_m == 0) ? 1 : 0;
    done_q.delete();
    fork
      xfer(0, 1'b1, 32'h20, 32'h1111, 4'hF, 1, e0, st0);
      xfer(1, 1'b1, 32'h24, 32'h2222, 4'hF, 1, e1, st1);
    join
    ref_wr(32'h20, 32'h1111, 4'hF);
    ref_wr(32'h24, 32'h2222, 4'hF);
    vectors++;
    if (done_q.size() != 2 || done_q[0] != exp_first || st0 != 0 || st1 != 0) begin
      miscompares++;
      $display("FAIL contention_order got_first=%0d st=%0d/%0d want_first=%0d", (done_q.size() > 0) ? done_q[0] : -1, st0, st1, exp_first);
    end
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1, e0, st0);
    vectors++;
    if (st0 != 0 || rd_buf[0][0] !== 32'h1111) begin
      miscompares++; $display("FAIL contention_rd20 got=%h st=%0d want=00001111", rd_buf[0][0], st0);
    end
    xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 1, e1, st1);
    vectors++;
    if (st1 != 0 || rd_buf[1][0] !== 32'h2222) begin
      miscompares++; $display("FAIL contention_rd24 got=%h st=%0d want=00002222", rd_buf[1][0], st1);
    end
  endtask

  task automatic test_single();
    bit e;
    int st, c1;
    c1 = ack_cnt[1];
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, e, st);
    ref_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    vectors++;
    if (st != 0 || e) begin
      miscompares++; $display("FAIL single_write st=%0d err=%b want st=0 err=0", st, e);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, e, st);
    vectors++;
    if (st != 0 || rd_buf[0][0] !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL single_read got=%h st=%0d want=deadbeef", rd_buf[0][0], st);
    end
    vectors++;
    if (ack_cnt[1] != c1) begin
      miscompares++; $display("FAIL single_m1_ack got=%0d acks want=0", ack_cnt[1] - c1);
    end
  endtask

  task automatic test_fairness();
    int exp_first;
    exp_first = (last_m == 0) ? 1 : 0;
    done_q.delete();
    fork
      begin
        bit e; int st; logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
          d = $urandom;
          xfer(0, 1'b1, 32'h200 + 32'(4 * i), d, 4'hF, 1, e, st);
          if (st == 0) ref_wr(32'h200 + 32'(4 * i), d, 4'hF);
        end
      end
      begin
        bit e; int st; logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
          d = $urandom;
          xfer(1, 1'b1, 32'h300 + 32'(4 * i), d, 4'hF, 1, e, st);
          if (st == 0) ref_wr(32'h300 + 32'(4 * i), d, 4'hF);
        end
      end
    join
    vectors++;
    if (done_q.size() != 16) begin
      miscompares++; $display("FAIL fair_count got=%0d want=16", done_q.size());
    end
    for (int i = 0; i < 16 && i < done_q.size(); i++) begin
      vectors++;
      if (done_q[i] != (exp_first ^ (i & 1))) begin
        miscompares++; $display("FAIL fair_order slot=%0d got=m%0d want=m%0d", i, done_q[i], exp_first ^ (i & 1));
      end
    end
  endtask

  task automatic test_lock();
    bit e0, e1;
    int st0, st1;
    done_q.delete();
    fork
      xfer(1, 1'b0, 32'h200, 32'h0, 4'hF, 4, e1, st1);
      begin
        repeat (2) @(posedge clk);
        #1;
        xfer(0, 1'b1, 32'h40, 32'hC0DE_0040, 4'hF, 1, e0, st0);
      end
    join
    ref_wr(32'h40, 32'hC0DE_0040, 4'hF);
    vectors++;
    if (done_q.size() != 2 || done_q[0] != 1 || st0 != 0 || st1 != 0) begin
      miscompares++; $display("FAIL lock_order got_first=%0d st=%0d/%0d want_first=1", (done_q.size() > 0) ? done_q[0] : -1, st0, st1);
    end
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (rd_buf[1][b] !== ref_rd(32'h200 + 32'(4 * b))) begin
        miscompares++; $display("FAIL lock_beat%0d got=%h want=%h", b, rd_buf[1][b], ref_rd(32'h200 + 32'(4 * b)));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit e0, e1;
    int st0, st1, cnt, c1;
    c1 = ack_cnt[1];
    fork
      xfer(1, 1'b0, 32'h300, 32'h0, 4'hF, 1, e1, st1);
      begin
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!s0_if.cyc && cnt < 50);
        vectors++;
        if (s0_if.cyc !== 1'b1) begin
          miscompares++; $display("FAIL mid_grant got s0.cyc=%b want=1", s0_if.cyc);
        end
        #1;
        rstn = 1'b0;
        #1;
        vectors++;
        if ({s0_if.cyc, s0_if.stb, m1_if.ack} !== 3'b000) begin
          miscompares++; $display("FAIL mid_drop got cyc/stb/ack=%b want=000", {s0_if.cyc, s0_if.stb, m1_if.ack});
        end
      end
    join
    vectors++;
    if (st1 != 2 || ack_cnt[1] != c1) begin
      miscompares++; $display("FAIL mid_no_ack got status=%0d acks=%0d want status=2 acks=0", st1, ack_cnt[1] - c1);
    end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    done_q.delete();
    fork
      xfer(0, 1'b1, 32'h60, 32'h6060_0000, 4'hF, 1, e0, st0);
      xfer(1, 1'b1, 32'h64, 32'h6464_0000, 4'hF, 1, e1, st1);
    join
    ref_wr(32'h60, 32'h6060_0000, 4'hF);
    ref_wr(32'h64, 32'h6464_0000, 4'hF);
    vectors++;
    if (done_q.size() != 2 || done_q[0] != 0) begin
      miscompares++; $display("FAIL mid_restart_prio got_first=%0d want=0", (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  task automatic rand_master(input int m, input int n);
    bit e, we, is_err;
    int st, gap;
    logic [31:0] adr, d;
    logic [3:0] sel;
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      we  = 1'($urandom_range(0, 1));
      adr = 32'(((m == 0) ? 256 : 320) + int'($urandom_range(0, 63))) << 2;
      if ($urandom_range(0, 7) == 0) adr = adr | 32'h1000;
      is_err = adr[12];
      sel = we ? 4'($urandom_range(1, 15)) : 4'hF;
      d   = $urandom;
      xfer(m, we, adr, d, sel, 1, e, st);
      vectors++;
      if (st != 0 || e !== is_err) begin
        miscompares++; $display("FAIL rand_resp m%0d adr=%h got st=%0d err=%b want st=0 err=%b", m, adr, st, e, is_err);
      end
      if (!is_err && st == 0) begin
        if (we) ref_wr(adr, d, sel);
        else begin
          vectors++;
          if (rd_buf[m][0] !== ref_rd(adr)) begin
            miscompares++; $display("FAIL rand_read m%0d adr=%h got=%h want=%h", m, adr, rd_buf[m][0], ref_rd(adr));
          end
        end
      end
    end
  endtask

  task automatic test_random();
    fork
      rand_master(0, 24);
      rand_master(1, 24);
    join
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_adr[m] = '0;   m_dat[m] = '0;   m_sel[m] = '0;
      ack_cnt[m] = 0;
    end
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_lock();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
